ts_word_serializer: RTL and testbench



---
 rtl/ts_word_serializer.sv | 129 ++++++++++++
 tb/tb_ts_word_serializer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_word_serializer.sv
// Wide-word to byte-stream unpacker for the DDR read path: gates TS packets
// to PKT_LEN bytes, drops pre-sync bytes, flags runt packets.
module ts_word_serializer #(
  parameter int unsigned WORD_BYTES = 64,
  parameter int unsigned PKT_LEN    = 188,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned DROP_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_BYTES*8:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [8:0]            dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  runt_pulse,
  output logic [DROP_W-1:0]     drop_cnt,
  output logic                  synced
);

  localparam int unsigned WB    = WORD_BYTES * 8;
  localparam int unsigned IDX_W = $clog2(WORD_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORD_BYTES - 1);
  localparam logic [CNT_W-1:0] PKT_LEN_C = CNT_W'(PKT_LEN);

  typedef enum logic {
    IDLE,
    UNPACK
  } state_e;

  state_e            state_q;
  logic [WB:0]       buf_q;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  pkt_cnt_q;
  logic [8:0]        dout_q;
  logic              dout_valid_q;
  logic              runt_q;
  logic [DROP_W-1:0] drop_cnt_q;
  logic              synced_q;

  logic [7:0] word_bytes [WORD_BYTES];
  logic [7:0] cur_byte;
  logic       cur_sop;
  logic       pkt_short;
  logic       keep;
  logic       advance;
  logic       last_idx;
  logic       accept;

  // Byte 0 sits in the most significant byte lane of the word
  for (genvar i = 0; i < int'(WORD_BYTES); i++) begin : g_lane
    assign word_bytes[i] = buf_q[WB-1-8*i -: 8];
  end

  always_comb begin
    cur_byte  = word_bytes[idx_q];
    cur_sop   = buf_q[WB] && (idx_q == '0);
    pkt_short = pkt_cnt_q < PKT_LEN_C;
    keep      = cur_sop || (synced_q && pkt_short);
    advance   = (state_q == UNPACK) && (!dout_valid_q || dout_ready);
    last_idx  = idx_q == LAST_IDX;
    din_ready = (state_q == IDLE) || (advance && last_idx);
    accept    = din_valid && din_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      buf_q        <= '0;
      idx_q        <= '0;
      pkt_cnt_q    <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      runt_q       <= 1'b0;
      drop_cnt_q   <= '0;
      synced_q     <= 1'b0;
    end else begin
      runt_q <= 1'b0;
      if (accept) begin
        buf_q <= din;
      end
      case (state_q)
        IDLE: begin
          if (dout_valid_q && dout_ready) begin
            dout_valid_q <= 1'b0;
          end
          if (accept) begin
            state_q <= UNPACK;
            idx_q   <= '0;
          end
        end
        UNPACK: begin
          if (advance) begin
            // Index wraps to 0 at the last lane; a new word loads the same cycle
            idx_q <= idx_q + IDX_W'(1);
            if (last_idx && !din_valid) begin
              state_q <= IDLE;
            end
            if (cur_sop) begin
              synced_q  <= 1'b1;
              pkt_cnt_q <= CNT_W'(1);
              runt_q    <= synced_q && pkt_short;
            end else if (keep) begin
              pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
            end
            if (keep) begin
              dout_q       <= {cur_sop, cur_byte};
              dout_valid_q <= 1'b1;
            end else begin
              dout_valid_q <= 1'b0;
              if (drop_cnt_q != '1) begin
                drop_cnt_q <= drop_cnt_q + DROP_W'(1);
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign runt_pulse = runt_q;
  assign drop_cnt   = drop_cnt_q;
  assign synced     = synced_q;

endmodule

// File: tb/tb_ts_word_serializer.sv
// Scoreboard bench for ts_word_serializer: stimulus pushes expected bytes,
// a negedge monitor pops and compares on every dout handshake.
module tb_ts_word_serializer;

  logic         clk = 1'b0;
  logic         rst;
  logic [512:0] din;
  logic         din_valid;
  logic         din_ready;
  logic [8:0]   dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         runt_pulse;
  logic [15:0]  drop_cnt;
  logic         synced;

  logic [32:0]  b_din;
  logic         b_din_valid;
  logic         b_din_ready;
  logic [8:0]   b_dout;
  logic         b_dout_valid;
  logic         b_runt;
  logic [3:0]   b_drop;
  logic         b_synced;

  int n_cmp = 0;
  int n_fail = 0;
  logic [8:0] exp_q [$];
  bit  m_synced;
  int  m_cnt;
  int  m_drop;
  int  beats;
  int  runt_seen;
  int  cur_low;
  int  max_low;
  bit  rand_ready = 1'b0;
  bit  held_prev = 1'b0;
  logic [8:0] held_dout;

  always #5 clk = ~clk;

  ts_word_serializer u_dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .runt_pulse(runt_pulse), .drop_cnt(drop_cnt), .synced(synced)
  );

  ts_word_serializer #(.WORD_BYTES(4), .PKT_LEN(8), .CNT_W(4), .DROP_W(4)) u_small (
    .clk(clk), .rst(rst), .din(b_din), .din_valid(b_din_valid), .din_ready(b_din_ready),
    .dout(b_dout), .dout_valid(b_dout_valid), .dout_ready(1'b1),
    .runt_pulse(b_runt), .drop_cnt(b_drop), .synced(b_synced)
  );

  task automatic check(input string nm, input longint unsigned act, input longint unsigned req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [512:0] mk_word(input bit sop, input logic [7:0] base);
    logic [512:0] w;
    logic [7:0]   b;
    w = '0;
    w[512] = sop;
    for (int i = 0; i < 64; i++) begin
      b = base + 8'(i);
      if (sop && i == 0) b = 8'h47;
      w[511-8*i -: 8] = b;
    end
    return w;
  endfunction

  // Stream-level reference: packet gating over the flat byte sequence
  task automatic model_push(input logic [512:0] w);
    logic [7:0] b;
    for (int i = 0; i < 64; i++) begin
      b = w[511-8*i -: 8];
      if (w[512] && i == 0) begin
        m_synced = 1'b1;
        m_cnt = 1;
        exp_q.push_back({1'b1, b});
      end else if (!m_synced) begin
        m_drop++;
      end else if (m_cnt < 188) begin
        m_cnt++;
        exp_q.push_back({1'b0, b});
      end else begin
        m_drop++;
      end
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_synced = 1'b0;
    m_cnt = 0;
    m_drop = 0;
    beats = 0;
    runt_seen = 0;
    max_low = 0;
    cur_low = 0;
  endtask

  task automatic send_word(input bit sop, input logic [7:0] base);
    logic [512:0] w;
    bit acc;
    bit done;
    w = mk_word(sop, base);
    model_push(w);
    din = w;
    din_valid = 1'b1;
    done = 1'b0;
    for (int g = 0; g < 1000 && !done; g++) begin
      @(negedge clk);
      acc = din_ready;
      @(posedge clk);
      #1;
      if (acc) done = 1'b1;
    end
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic drain(input int limit);
    int quiet;
    quiet = 0;
    for (int g = 0; g < limit && quiet < 3; g++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !dout_valid && din_ready) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) check("drain_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    din_valid = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic feed_b(input int n);
    int got;
    bit acc;
    got = 0;
    b_din_valid = 1'b1;
    for (int g = 0; g < 200 && got < n; g++) begin
      @(negedge clk);
      acc = b_din_ready;
      @(posedge clk);
      #1;
      if (acc) got++;
    end
    b_din_valid = 1'b0;
    if (got < n) check("small_feed_timeout", 0, 1);
    repeat (8) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (rand_ready) dout_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: hold stability, scoreboard pop, runt alignment, din_ready low runs
  always @(negedge clk) begin
    if (rst) begin
      held_prev = 1'b0;
    end else begin
      if (!din_ready) begin
        cur_low++;
        if (cur_low > max_low) max_low = cur_low;
      end else begin
        cur_low = 0;
      end
      if (held_prev) begin
        check("hold_valid", dout_valid, 1);
        check("hold_data", dout, held_dout);
      end
      if (dout_valid && dout_ready) begin
        beats++;
        if (exp_q.size() == 0) check("unexpected_beat", dout, 9'h1ff);
        else check("beat_data", dout, exp_q.pop_front());
      end
      if (runt_pulse) begin
        runt_seen++;
        check("runt_on_sop", {dout_valid, dout[8]}, 2'b11);
      end
      held_prev = dout_valid && !dout_ready;
      held_dout = dout;
    end
  end

  initial begin
    rst = 1'b1;
    din = '0;
    din_valid = 1'b0;
    dout_ready = 1'b1;
    b_din = {1'b0, 32'h01020304};
    b_din_valid = 1'b0;
    model_clear();

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_din_ready", din_ready, 1);
    check("rst_dout", dout, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_runt", runt_pulse, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_synced", synced, 0);
    rst = 1'b0;

    // Two unsynced words, then SOP word: first byte is {1,0x47}
    send_word(1'b0, 8'h00);
    send_word(1'b0, 8'h40);
    send_word(1'b1, 8'hff);
    din_valid = 1'b0;
    check("p1_no_early_valid", dout_valid, 0);
    check("p1_synced_before", synced, 0);
    @(posedge clk);
    #1;
    check("p1_first_valid", dout_valid, 1);
    check("p1_first_byte", dout, 9'h147);
    check("p1_synced", synced, 1);
    check("p1_drop_at_sop", drop_cnt, 128);
    drain(500);
    check("p1_drop_end", drop_cnt, 128);
    check("p1_beats", beats, 64);

    // One SOP word plus 256 bytes: 188 kept, 132 dropped
    do_reset();
    send_word(1'b1, 8'hff);
    send_word(1'b0, 8'h40);
    send_word(1'b0, 8'h80);
    send_word(1'b0, 8'hc0);
    send_word(1'b0, 8'h00);
    din_valid = 1'b0;
    drain(1000);
    check("p2_beats", beats, 188);
    check("p2_drop", drop_cnt, 132);
    check("p2_max_ready_low", max_low, 63);
    check("p2_no_runt", runt_seen, 0);

    // Full packet then a 128-byte packet: only the second new SOP is a runt
    send_word(1'b1, 8'h10);
    send_word(1'b0, 8'h20);
    send_word(1'b1, 8'h30);
    din_valid = 1'b0;
    drain(1000);
    check("p3_runt_count", runt_seen, 1);
    check("p3_beats", beats, 380);
    check("p3_drop", drop_cnt, 132);
    check("p3_drop_model", drop_cnt, longint'(m_drop));

    // Same stream as the ready-high run, with random backpressure
    do_reset();
    rand_ready = 1'b1;
    send_word(1'b1, 8'hff);
    send_word(1'b0, 8'h40);
    send_word(1'b0, 8'h80);
    send_word(1'b0, 8'hc0);
    send_word(1'b0, 8'h00);
    din_valid = 1'b0;
    drain(4000);
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    dout_ready = 1'b1;
    check("p4_beats", beats, 188);
    check("p4_drop", drop_cnt, 132);

    // Reset asserted mid-word at index 30
    do_reset();
    send_word(1'b1, 8'hff);
    din_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    model_clear();
    #1;
    check("p5_rst_dout", dout, 0);
    check("p5_rst_valid", dout_valid, 0);
    check("p5_rst_synced", synced, 0);
    check("p5_rst_drop", drop_cnt, 0);
    repeat (2) @(posedge clk);
    #1;
    check("p5_rst_hold_valid", dout_valid, 0);
    rst = 1'b0;
    check("p5_release_drop", drop_cnt, 0);
    send_word(1'b1, 8'h60);
    din_valid = 1'b0;
    @(posedge clk);
    #1;
    check("p5_first_after_rst", {dout_valid, dout}, {1'b1, 9'h147});
    drain(500);
    check("p5_beats", beats, 64);

    // Narrow drop counter saturates
    feed_b(3);
    check("small_drop_12", b_drop, 12);
    feed_b(2);
    check("small_drop_sat", b_drop, 15);
    feed_b(1);
    check("small_drop_stays", b_drop, 15);
    check("small_synced", b_synced, 0);
    check("small_no_output", {b_dout_valid, b_runt, b_dout}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
